regfile_write_scheduler: RTL and testbench

Shares the register file's single write port between two writeback sources: the ALU result path and the memory-load result path. It also keeps a 32-entry busy scoreboard, so decode can detect read-after-write hazards on RS and RT and stall. It sits between the execute/memory stages and the register file. It drives the register file's write_address, data_in and WriteEnable from registers clocked on the posedge; the register file commits on the following negedge.

---
 rtl/regfile_write_scheduler_if.sv | 39 +++
 rtl/regfile_write_scheduler.sv | 99 +++++++++
 tb/tb_regfile_write_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_if.sv
// Writeback request, decode hazard and register-file write bundle for regfile_write_scheduler.
// slave = the scheduler, master = the pipeline side driving requests.
interface regfile_write_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic              WriteEnable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data_in;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, rs_addr, rt_addr,
    output alu_ready, mem_ready, issue_ready, rs_busy, rt_busy,
           WriteEnable, write_address, data_in
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, rs_addr, rt_addr,
    input  alu_ready, mem_ready, issue_ready, rs_busy, rt_busy,
           WriteEnable, write_address, data_in
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU/load writebacks onto the single register-file write port and keeps a busy scoreboard.
// `define WB_FORWARD_EN adds write-cycle forwarding outputs for RS/RT.
module regfile_write_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic clock,
  input  logic reset,
  regfile_write_scheduler_if.slave bus
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_rs_valid,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_valid,
  output logic [DATA_W-1:0] fwd_rt_data
`endif
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e                last_grant, last_grant_nxt;
  logic                grant_alu, grant_mem;
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic                set_en;

  // Round-robin between the two sources; a lone requester always wins.
  always_comb begin
    grant_alu      = 1'b0;
    grant_mem      = 1'b0;
    last_grant_nxt = last_grant;
    if (bus.alu_valid && (!bus.mem_valid || last_grant == SRC_MEM)) begin
      grant_alu      = 1'b1;
      last_grant_nxt = SRC_ALU;
    end else if (bus.mem_valid) begin
      grant_mem      = 1'b1;
      last_grant_nxt = SRC_MEM;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_grant <= SRC_MEM;
    else        last_grant <= last_grant_nxt;
  end

  // Write stage: one cycle deep, so a new grant is accepted every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.WriteEnable   <= 1'b0;
      bus.write_address <= '0;
      bus.data_in       <= '0;
    end else if (grant_alu) begin
      bus.WriteEnable   <= (bus.alu_addr != '0);
      bus.write_address <= bus.alu_addr;
      bus.data_in       <= bus.alu_data;
    end else if (grant_mem) begin
      bus.WriteEnable   <= (bus.mem_addr != '0);
      bus.write_address <= bus.mem_addr;
      bus.data_in       <= bus.mem_data;
    end else begin
      bus.WriteEnable   <= 1'b0;
    end
  end

  // Scoreboard: a bit clears at the posedge ending its write cycle; a same-edge reservation wins.
  assign bus.issue_ready = !busy[bus.issue_addr];
  assign set_en          = bus.issue_valid && bus.issue_ready && (bus.issue_addr != '0);

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (set_en && bus.issue_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
      else if (bus.WriteEnable && bus.write_address == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef WB_FORWARD_EN
  assign fwd_rs_valid = bus.WriteEnable && (bus.rs_addr != '0) && (bus.write_address == bus.rs_addr);
  assign fwd_rt_valid = bus.WriteEnable && (bus.rt_addr != '0) && (bus.write_address == bus.rt_addr);
  assign fwd_rs_data  = bus.data_in;
  assign fwd_rt_data  = bus.data_in;
  assign bus.rs_busy  = busy[bus.rs_addr] && (bus.rs_addr != '0) && !fwd_rs_valid;
  assign bus.rt_busy  = busy[bus.rt_addr] && (bus.rt_addr != '0) && !fwd_rt_valid;
`else
  assign bus.rs_busy  = busy[bus.rs_addr] && (bus.rs_addr != '0);
  assign bus.rt_busy  = busy[bus.rt_addr] && (bus.rt_addr != '0);
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed vector bench for regfile_write_scheduler: per-cycle table plus reset and forwarding sequences.
module tb_regfile_write_scheduler;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clock;
  logic reset;

  regfile_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef WB_FORWARD_EN
  logic              fwd_rs_valid, fwd_rt_valid;
  logic [DATA_W-1:0] fwd_rs_data, fwd_rt_data;
`endif

  regfile_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef WB_FORWARD_EN
    ,
    .fwd_rs_valid (fwd_rs_valid),
    .fwd_rs_data  (fwd_rs_data),
    .fwd_rt_valid (fwd_rt_valid),
    .fwd_rt_data  (fwd_rt_data)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected registered outputs reflect the grant made at the previous posedge.
  typedef struct {
    logic              av;  logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad;
    logic              mv;  logic [ADDR_W-1:0] ma; logic [DATA_W-1:0] md;
    logic              iv;  logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] rs;  logic [ADDR_W-1:0] rt;
    logic ear, emr, eir, ersb, ertb;
    logic              ewe; logic [ADDR_W-1:0] ewa; logic [DATA_W-1:0] ewd;
  } vec_t;

  vec_t tbl [19];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
    input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
    input logic iv, input logic [ADDR_W-1:0] ia,
    input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
    input logic ear, input logic emr, input logic eir, input logic ersb, input logic ertb,
    input logic ewe, input logic [ADDR_W-1:0] ewa, input logic [DATA_W-1:0] ewd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.iv = iv; v.ia = ia; v.rs = rs; v.rt = rt;
    v.ear = ear; v.emr = emr; v.eir = eir; v.ersb = ersb; v.ertb = ertb;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic exp_rsb, exp_rtb;
    @(negedge clock);
    bus.alu_valid = v.av; bus.alu_addr = v.aa; bus.alu_data = v.ad;
    bus.mem_valid = v.mv; bus.mem_addr = v.ma; bus.mem_data = v.md;
    bus.issue_valid = v.iv; bus.issue_addr = v.ia;
    bus.rs_addr = v.rs; bus.rt_addr = v.rt;
    #1;
    exp_rsb = v.ersb;
    exp_rtb = v.ertb;
`ifdef WB_FORWARD_EN
    begin
      logic fv_rs, fv_rt;
      fv_rs = v.ewe && (v.ewa == v.rs) && (v.rs != '0);
      fv_rt = v.ewe && (v.ewa == v.rt) && (v.rt != '0);
      if (fv_rs) exp_rsb = 1'b0;
      if (fv_rt) exp_rtb = 1'b0;
      chk({tag, " fwd_rs_valid"}, 32'(fwd_rs_valid), 32'(fv_rs));
      chk({tag, " fwd_rt_valid"}, 32'(fwd_rt_valid), 32'(fv_rt));
      chk({tag, " fwd_rs_data"},  fwd_rs_data, v.ewd);
    end
`endif
    chk({tag, " alu_ready"},     32'(bus.alu_ready),     32'(v.ear));
    chk({tag, " mem_ready"},     32'(bus.mem_ready),     32'(v.emr));
    chk({tag, " issue_ready"},   32'(bus.issue_ready),   32'(v.eir));
    chk({tag, " rs_busy"},       32'(bus.rs_busy),       32'(exp_rsb));
    chk({tag, " rt_busy"},       32'(bus.rt_busy),       32'(exp_rtb));
    chk({tag, " WriteEnable"},   32'(bus.WriteEnable),   32'(v.ewe));
    chk({tag, " write_address"}, 32'(bus.write_address), 32'(v.ewa));
    chk({tag, " data_in"},       bus.data_in,            v.ewd);
  endtask

  initial begin
    //             av aa  ad        mv ma  md        iv ia  rs  rt   ar mr ir rsb rtb we wa  wd
    tbl[0]  = mk(0, 0, 0,          0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 5, 32'h1234,   0, 0, 0,          0, 0, 0, 0,  1, 0, 1, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0,          0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 0, 0,  1, 5, 32'h1234);
    tbl[3]  = mk(0, 0, 0,          0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 5, 32'h1234);
    tbl[4]  = mk(1, 1, 32'hA1,     1, 2, 32'hB2,     0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 5, 32'h1234);
    tbl[5]  = mk(1, 1, 32'hA1,     1, 3, 32'hB3,     0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 2, 32'hB2);
    tbl[6]  = mk(1, 4, 32'hA4,     1, 3, 32'hB3,     0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 1, 32'hA1);
    tbl[7]  = mk(1, 4, 32'hA4,     0, 0, 0,          0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 3, 32'hB3);
    tbl[8]  = mk(0, 0, 0,          0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 0, 0,  1, 4, 32'hA4);
    tbl[9]  = mk(0, 0, 0,          0, 0, 0,          1, 7, 7, 0,  0, 0, 1, 0, 0,  0, 4, 32'hA4);
    tbl[10] = mk(0, 0, 0,          0, 0, 0,          1, 7, 7, 7,  0, 0, 0, 1, 1,  0, 4, 32'hA4);
    tbl[11] = mk(1, 7, 32'h77,     0, 0, 0,          0, 0, 7, 0,  1, 0, 1, 1, 0,  0, 4, 32'hA4);
    tbl[12] = mk(0, 0, 0,          0, 0, 0,          0, 0, 7, 0,  0, 0, 1, 1, 0,  1, 7, 32'h77);
    tbl[13] = mk(0, 0, 0,          0, 0, 0,          1, 7, 7, 0,  0, 0, 1, 0, 0,  0, 7, 32'h77);
    tbl[14] = mk(1, 8, 32'h88,     0, 0, 0,          0, 0, 7, 8,  1, 0, 1, 1, 0,  0, 7, 32'h77);
    tbl[15] = mk(0, 0, 0,          0, 0, 0,          1, 8, 7, 8,  0, 0, 1, 1, 0,  1, 8, 32'h88);
    tbl[16] = mk(0, 0, 0,          0, 0, 0,          0, 0, 8, 7,  0, 0, 1, 1, 1,  0, 8, 32'h88);
    tbl[17] = mk(0, 0, 0,          1, 0, 32'hFFFF,   1, 0, 0, 0,  0, 1, 1, 0, 0,  0, 8, 32'h88);
    tbl[18] = mk(0, 0, 0,          0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 32'hFFFF);

    reset = 1'b0;
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.issue_valid = 0; bus.issue_addr = '0;
    bus.rs_addr = '0; bus.rt_addr = '0;
    #3;
    chk("reset WriteEnable",   32'(bus.WriteEnable),   32'd0);
    chk("reset write_address", 32'(bus.write_address), 32'd0);
    chk("reset data_in",       bus.data_in,            32'd0);
    chk("reset issue_ready",   32'(bus.issue_ready),   32'd1);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reserve 3 and 9, put a write of 9 in flight, then reset mid low phase.
    step(mk(0, 0, 0,       0, 0, 0, 1, 3, 0, 0,  0, 0, 1, 0, 0,  0, 0, 32'hFFFF), "rst_a");
    step(mk(1, 9, 32'h99,  0, 0, 0, 1, 9, 3, 9,  1, 0, 1, 1, 0,  0, 0, 32'hFFFF), "rst_b");
    step(mk(0, 0, 0,       0, 0, 0, 0, 0, 3, 9,  0, 0, 1, 1, 1,  1, 9, 32'h99),   "rst_c");
    #2 reset = 1'b0;
    #1;
    chk("async WriteEnable",   32'(bus.WriteEnable),   32'd0);
    chk("async write_address", 32'(bus.write_address), 32'd0);
    chk("async data_in",       bus.data_in,            32'd0);
    chk("async rs_busy r3",    32'(bus.rs_busy),       32'd0);
    chk("async rt_busy r9",    32'(bus.rt_busy),       32'd0);
    bus.rs_addr = 5'd7; bus.rt_addr = 5'd8;
    #1;
    chk("async rs_busy r7",    32'(bus.rs_busy),       32'd0);
    chk("async rt_busy r8",    32'(bus.rt_busy),       32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Both sources contend right after reset: ALU, MEM, ALU, then MEM drains.
    step(mk(1, 1, 32'h11,  1, 2, 32'h22, 0, 0, 0, 0,  1, 0, 1, 0, 0,  0, 0, 32'h0),  "rr0");
    step(mk(1, 4, 32'h44,  1, 2, 32'h22, 0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 1, 32'h11), "rr1");
    step(mk(1, 4, 32'h44,  1, 5, 32'h55, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 2, 32'h22), "rr2");
    step(mk(0, 0, 0,       1, 5, 32'h55, 0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 4, 32'h44), "rr3");
    step(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0,  0, 0, 1, 0, 0,  1, 5, 32'h55), "rr4");
    step(mk(0, 0, 0,       0, 0, 0,      0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 5, 32'h55), "rr5");

    // Reserved reg 4 written with 0xBEEF while RS reads it.
    step(mk(0, 0, 0,         0, 0, 0, 1, 4, 4, 0,  0, 0, 1, 0, 0,  0, 5, 32'h55),   "fw0");
    step(mk(1, 4, 32'hBEEF,  0, 0, 0, 0, 0, 4, 0,  1, 0, 1, 1, 0,  0, 5, 32'h55),   "fw1");
    step(mk(0, 0, 0,         0, 0, 0, 0, 0, 4, 0,  0, 0, 1, 1, 0,  1, 4, 32'hBEEF), "fw2");
    step(mk(0, 0, 0,         0, 0, 0, 0, 0, 4, 0,  0, 0, 1, 0, 0,  0, 4, 32'hBEEF), "fw3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
